// File: rtl/usbfs_tx_buf_arb.sv
// Round-robin arbiter for the shared USB full-speed TX packet-buffer write port.
// One endpoint owns the buffer per packet; the committed packet is held until the transaction layer releases it.
module usbfs_tx_buf_arb #(
  parameter int N_ENDP  = 2,
  parameter int MAX_PKT = 8,
  localparam int WRIDX_W  = $clog2(MAX_PKT),
  localparam int NBYTES_W = $clog2(MAX_PKT + 1),
  localparam int ENDP_W   = $clog2(N_ENDP)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [N_ENDP-1:0]            i_req,
  output logic [N_ENDP-1:0]            o_gnt,
  input  logic [N_ENDP-1:0]            i_wrEn,
  input  logic [N_ENDP*WRIDX_W-1:0]    i_wrIdx,
  input  logic [N_ENDP*8-1:0]          i_wrByte,
  input  logic [N_ENDP-1:0]            i_commit,
  input  logic [N_ENDP*NBYTES_W-1:0]   i_commitNBytes,
  output logic                         o_wrEn,
  output logic [WRIDX_W-1:0]           o_wrIdx,
  output logic [7:0]                   o_wrByte,
  output logic                         o_pktValid,
  output logic [ENDP_W-1:0]            o_pktEndp,
  output logic [NBYTES_W-1:0]          o_pktNBytes,
  input  logic                         i_pktDone,
  output logic                         o_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ENDP_W-1:0]     owner_q, owner_d;
  logic [ENDP_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [N_ENDP-1:0]     gnt_d;
  logic                  pkt_valid_d;
  logic [ENDP_W-1:0]     pkt_endp_d;
  logic [NBYTES_W-1:0]   pkt_nbytes_d;
  logic                  err_d;

  logic                  arb_found;
  logic [ENDP_W-1:0]     arb_idx;
  int                    cand;

  logic                  owner_gnt;
  logic                  owner_commit;
  logic                  owner_req;
  logic [NBYTES_W-1:0]   commit_raw;
  logic                  commit_over;
  logic [NBYTES_W-1:0]   commit_cnt;
  logic                  stray_wr;
  logic                  stray_commit;

  // Search starts one past the last grant, so the last winner has lowest priority.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= N_ENDP; k++) begin
      cand = (int'(rr_ptr_q) + k) % N_ENDP;
      if (!arb_found && i_req[cand]) begin
        arb_found = 1'b1;
        arb_idx   = ENDP_W'(cand);
      end
    end
  end

  // Owner-side view: o_gnt is only ever set in FILL, so it doubles as "owner valid".
  always_comb begin
    owner_gnt    = o_gnt[owner_q];
    owner_req    = i_req[owner_q];
    owner_commit = owner_gnt & i_commit[owner_q];
    commit_raw   = i_commitNBytes[int'(owner_q)*NBYTES_W +: NBYTES_W];
    commit_over  = (commit_raw > NBYTES_W'(MAX_PKT));
    commit_cnt   = commit_over ? NBYTES_W'(MAX_PKT) : commit_raw;
    stray_wr     = |(i_wrEn & ~o_gnt);
    stray_commit = |(i_commit & ~o_gnt);
  end

  // Write path is purely combinational so the owner's first write lands in the grant cycle.
  always_comb begin
    o_wrEn   = owner_gnt & i_wrEn[owner_q];
    o_wrIdx  = i_wrIdx[int'(owner_q)*WRIDX_W +: WRIDX_W];
    o_wrByte = i_wrByte[int'(owner_q)*8 +: 8];
  end

  // Packet handoff: o_pktValid stays high (with endpoint and length stable) until
  // the transaction layer answers with a one-cycle i_pktDone; no grant while held.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    gnt_d        = o_gnt;
    pkt_valid_d  = o_pktValid;
    pkt_endp_d   = o_pktEndp;
    pkt_nbytes_d = o_pktNBytes;
    err_d        = stray_wr | stray_commit;

    case (state_q)
      IDLE: begin
        gnt_d       = '0;
        pkt_valid_d = 1'b0;
        if (arb_found) begin
          gnt_d          = '0;
          gnt_d[arb_idx] = 1'b1;
          owner_d        = arb_idx;
          rr_ptr_d       = arb_idx;
          state_d        = FILL;
        end
      end
      FILL: begin
        if (owner_commit) begin
          pkt_valid_d  = 1'b1;
          pkt_endp_d   = owner_q;
          pkt_nbytes_d = commit_cnt;
          gnt_d        = '0;
          state_d      = PEND;
          if (commit_over) begin
            err_d = 1'b1;
          end
        end else if (!owner_req) begin
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      PEND: begin
        gnt_d = '0;
        if (i_pktDone) begin
          pkt_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        gnt_d       = '0;
        pkt_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= ENDP_W'(N_ENDP - 1);
      o_gnt       <= '0;
      o_pktValid  <= 1'b0;
      o_pktEndp   <= '0;
      o_pktNBytes <= '0;
      o_err       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      o_gnt       <= gnt_d;
      o_pktValid  <= pkt_valid_d;
      o_pktEndp   <= pkt_endp_d;
      o_pktNBytes <= pkt_nbytes_d;
      o_err       <= err_d;
    end
  end

endmodule

// File: tb/tb_usbfs_tx_buf_arb.sv
// Directed bench for usbfs_tx_buf_arb (N_ENDP=2, MAX_PKT=8).
module tb_usbfs_tx_buf_arb;

  localparam int N_ENDP   = 2;
  localparam int MAX_PKT  = 8;
  localparam int WRIDX_W  = 3;
  localparam int NBYTES_W = 4;
  localparam int ENDP_W   = 1;

  logic                       clk;
  logic                       rst;
  logic [N_ENDP-1:0]          req;
  logic [N_ENDP-1:0]          gnt;
  logic [N_ENDP-1:0]          wr_en;
  logic [N_ENDP*WRIDX_W-1:0]  wr_idx;
  logic [N_ENDP*8-1:0]        wr_byte;
  logic [N_ENDP-1:0]          commit;
  logic [N_ENDP*NBYTES_W-1:0] commit_nbytes;
  logic                       o_wr_en;
  logic [WRIDX_W-1:0]         o_wr_idx;
  logic [7:0]                 o_wr_byte;
  logic                       pkt_valid;
  logic [ENDP_W-1:0]          pkt_endp;
  logic [NBYTES_W-1:0]        pkt_nbytes;
  logic                       pkt_done;
  logic                       err;

  int checks = 0;
  int errors = 0;

  usbfs_tx_buf_arb #(.N_ENDP(N_ENDP), .MAX_PKT(MAX_PKT)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req          (req),
    .o_gnt          (gnt),
    .i_wrEn         (wr_en),
    .i_wrIdx        (wr_idx),
    .i_wrByte       (wr_byte),
    .i_commit       (commit),
    .i_commitNBytes (commit_nbytes),
    .o_wrEn         (o_wr_en),
    .o_wrIdx        (o_wr_idx),
    .o_wrByte       (o_wr_byte),
    .o_pktValid     (pkt_valid),
    .o_pktEndp      (pkt_endp),
    .o_pktNBytes    (pkt_nbytes),
    .i_pktDone      (pkt_done),
    .o_err          (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req           = '0;
    wr_en         = '0;
    wr_idx        = '0;
    wr_byte       = '0;
    commit        = '0;
    commit_nbytes = '0;
    pkt_done      = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b exp 00", gnt); end
    checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", pkt_valid); end
    checks++; if (pkt_endp !== 1'b0) begin errors++; $display("FAIL reset_endp got %0d exp 0", pkt_endp); end
    checks++; if (pkt_nbytes !== 4'd0) begin errors++; $display("FAIL reset_nbytes got %0d exp 0", pkt_nbytes); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    checks++; if (o_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wren got %b exp 0", o_wr_en); end
  endtask

  task automatic test_fill_commit();
    req = 2'b01;
    cyc();
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL fill_gnt got %b exp 01", gnt); end
    for (int i = 0; i < 8; i++) begin
      wr_en        = 2'b01;
      wr_idx[2:0]  = 3'(i);
      wr_byte[7:0] = 8'hA0 + 8'(i);
      #1;
      checks++;
      if (o_wr_en !== 1'b1 || o_wr_idx !== 3'(i) || o_wr_byte !== 8'hA0 + 8'(i)) begin
        errors++;
        $display("FAIL fill_write%0d got en=%b idx=%0d byte=%h exp en=1 idx=%0d byte=%h",
                 i, o_wr_en, o_wr_idx, o_wr_byte, i, 8'hA0 + 8'(i));
      end
      cyc();
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL fill_err%0d got %b exp 0", i, err); end
    end
    wr_en              = '0;
    commit             = 2'b01;
    commit_nbytes[3:0] = 4'd8;
    cyc();
    commit = '0;
    req    = '0;
    checks++;
    if (pkt_valid !== 1'b1 || pkt_endp !== 1'b0 || pkt_nbytes !== 4'd8 || gnt !== 2'b00) begin
      errors++;
      $display("FAIL fill_commit got v=%b ep=%0d n=%0d gnt=%b exp v=1 ep=0 n=8 gnt=00",
               pkt_valid, pkt_endp, pkt_nbytes, gnt);
    end
    pkt_done = 1'b1;
    cyc();
    pkt_done = 1'b0;
    checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL fill_done got %b exp 0", pkt_valid); end
  endtask

  task automatic test_round_robin();
    idle_inputs();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      int e;
      e = i % 2;
      cyc();
      checks++;
      if (gnt !== 2'(1 << e)) begin errors++; $display("FAIL rr_gnt%0d got %b exp %b", i, gnt, 2'(1 << e)); end
      commit                 = '0;
      commit[e]              = 1'b1;
      commit_nbytes          = '0;
      commit_nbytes[e*4 +: 4] = 4'd2;
      cyc();
      commit = '0;
      checks++;
      if (pkt_valid !== 1'b1 || pkt_endp !== 1'(e) || pkt_nbytes !== 4'd2 || gnt !== 2'b00) begin
        errors++;
        $display("FAIL rr_commit%0d got v=%b ep=%0d n=%0d gnt=%b exp v=1 ep=%0d n=2 gnt=00",
                 i, pkt_valid, pkt_endp, pkt_nbytes, gnt, e);
      end
      pkt_done = 1'b1;
      cyc();
      pkt_done = 1'b0;
      checks++;
      if (pkt_valid !== 1'b0 || gnt !== 2'b00) begin
        errors++;
        $display("FAIL rr_done%0d got v=%b gnt=%b exp v=0 gnt=00", i, pkt_valid, gnt);
      end
    end
    idle_inputs();
  endtask

  task automatic test_stray_write();
    logic [1:0] en_tab  [5];
    logic       fwd_tab [5];
    en_tab  = '{2'b11, 2'b01, 2'b11, 2'b01, 2'b10};
    fwd_tab = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    req = 2'b01;
    cyc();
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL stray_gnt got %b exp 01", gnt); end
    for (int k = 0; k < 5; k++) begin
      wr_en         = en_tab[k];
      wr_idx        = {3'd7, 3'(k)};
      wr_byte       = {8'hEE, 8'h50 + 8'(k)};
      #1;
      checks++;
      if (o_wr_en !== fwd_tab[k] || (fwd_tab[k] && o_wr_byte !== 8'h50 + 8'(k))) begin
        errors++;
        $display("FAIL stray_fwd%0d got en=%b byte=%h exp en=%b byte=%h",
                 k, o_wr_en, o_wr_byte, fwd_tab[k], 8'h50 + 8'(k));
      end
      cyc();
      checks++;
      if (err !== en_tab[k][1]) begin errors++; $display("FAIL stray_err%0d got %b exp %b", k, err, en_tab[k][1]); end
    end
    wr_en  = '0;
    commit = 2'b10;
    cyc();
    commit = '0;
    checks++;
    if (err !== 1'b1 || gnt !== 2'b01 || pkt_valid !== 1'b0) begin
      errors++;
      $display("FAIL stray_commit got err=%b gnt=%b v=%b exp err=1 gnt=01 v=0", err, gnt, pkt_valid);
    end
    cyc();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL stray_err_clear got %b exp 0", err); end
  endtask

  task automatic test_zero_length();
    commit        = 2'b01;
    commit_nbytes = '0;
    cyc();
    commit = '0;
    req    = '0;
    checks++;
    if (pkt_valid !== 1'b1 || pkt_nbytes !== 4'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL zlp got v=%b n=%0d err=%b exp v=1 n=0 err=0", pkt_valid, pkt_nbytes, err);
    end
    pkt_done = 1'b1;
    cyc();
    pkt_done = 1'b0;
  endtask

  task automatic test_clamp();
    pkt_done = 1'b1;
    cyc();
    pkt_done = 1'b0;
    checks++;
    if (err !== 1'b0 || pkt_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_done got err=%b v=%b exp err=0 v=0", err, pkt_valid);
    end
    req = 2'b01;
    cyc();
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL clamp_gnt got %b exp 01", gnt); end
    commit             = 2'b01;
    commit_nbytes[3:0] = 4'd9;
    cyc();
    commit = '0;
    req    = '0;
    checks++;
    if (pkt_valid !== 1'b1 || pkt_nbytes !== 4'd8 || err !== 1'b1) begin
      errors++;
      $display("FAIL clamp got v=%b n=%0d err=%b exp v=1 n=8 err=1", pkt_valid, pkt_nbytes, err);
    end
    pkt_done = 1'b1;
    cyc();
    pkt_done = 1'b0;
    commit_nbytes = '0;
  endtask

  task automatic test_abort();
    req = 2'b01;
    cyc();
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL abort_gnt got %b exp 01", gnt); end
    req = 2'b10;
    cyc();
    checks++;
    if (gnt !== 2'b00 || pkt_valid !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL abort got gnt=%b v=%b err=%b exp gnt=00 v=0 err=0", gnt, pkt_valid, err);
    end
    cyc();
    checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL abort_next got %b exp 10", gnt); end
    req = '0;
    cyc();
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL abort_ep1 got %b exp 00", gnt); end
  endtask

  task automatic test_rst_pend();
    req = 2'b01;
    cyc();
    commit             = 2'b01;
    commit_nbytes[3:0] = 4'd5;
    cyc();
    commit = '0;
    checks++;
    if (pkt_valid !== 1'b1 || pkt_nbytes !== 4'd5) begin
      errors++;
      $display("FAIL pend_setup got v=%b n=%0d exp v=1 n=5", pkt_valid, pkt_nbytes);
    end
    req = 2'b11;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++;
    if (gnt !== 2'b00 || pkt_valid !== 1'b0 || pkt_endp !== 1'b0 || pkt_nbytes !== 4'd0 ||
        err !== 1'b0 || o_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL pend_rst got gnt=%b v=%b ep=%0d n=%0d err=%b wren=%b exp all 0",
               gnt, pkt_valid, pkt_endp, pkt_nbytes, err, o_wr_en);
    end
    cyc();
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL post_rst_gnt got %b exp 01", gnt); end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_fill_commit();
    test_round_robin();
    test_stray_write();
    test_zero_length();
    test_clamp();
    test_abort();
    test_rst_pend();
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
